// File: rtl/instr_fetch_pkg.sv
// Shared types and default constants for the instruction fetch unit.
// Holds the fetch FSM state encoding and the default address/word widths,
// reset PC, halt word and memory timeout used by instr_fetch.
package instr_fetch_pkg;

  localparam int          DEF_AW        = 8;
  localparam int          DEF_DW        = 16;
  localparam int          DEF_RESET_PC  = 0;
  localparam logic [15:0] DEF_HALT_WORD = 16'hFF00;
  localparam int          DEF_TIMEOUT   = 15;

  typedef logic [DEF_AW-1:0] addr_t;
  typedef logic [DEF_DW-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DELIVER,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Memory wait timer for the fetch unit.
// Ports: clk, rst (sync, active-high), clear (reload), enable (count one
// WAIT cycle), expired (high during the TIMEOUT-th enabled cycle).
// Implemented as a down-counter: reload to TIMEOUT-1 so that the terminal
// count (zero) is reached in the TIMEOUT-th cycle after a clear.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 15,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= CW'(TIMEOUT - 1);
    end else if (enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads instruction memory one word at
// a time and writes each fetched word onto the IR load bus.
// Ports: clk, rst (sync, active-high); fetch_req/jump/jump_addr from the CU;
// im_addr/im_rd/im_data/im_valid to instruction memory; ir_data/ir_wr to the
// IR; status pc, busy, halted (sticky), fault (sticky).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for fetch_req or a pending request
// REQ      | one-cycle memory read strobe at pc
// WAIT     | waiting for im_valid, timer running
// DELIVER  | one-cycle IR write, pc advances (or takes the jump target)
// HALT     | halt word fetched or memory timed out; only jump/rst leave
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int             AW        = DEF_AW,
  parameter int             DW        = DEF_DW,
  parameter logic [AW-1:0]  RESET_PC  = AW'(DEF_RESET_PC),
  parameter logic [DW-1:0]  HALT_WORD = DW'(DEF_HALT_WORD),
  parameter int             TIMEOUT   = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic          jump,
  input  logic [AW-1:0] jump_addr,
  output logic [AW-1:0] im_addr,
  output logic          im_rd,
  input  logic [DW-1:0] im_data,
  input  logic          im_valid,
  output logic [DW-1:0] ir_data,
  output logic          ir_wr,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          fault
);

  fetch_state_t  state, state_next;
  logic [AW-1:0] pc_next;
  logic          pending, pending_next;
  logic          discard, discard_next;
  logic          halted_next, fault_next;
  logic          expired;
  logic          im_rd_d, ir_wr_d, busy_d;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == S_REQ),
    .enable  (state == S_WAIT),
    .expired (expired)
  );

  // State and output registers. Outputs are registered from the next-state
  // decode so that each strobe lines up with the cycle its state is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      im_addr <= RESET_PC;
      im_rd   <= 1'b0;
      ir_wr   <= 1'b0;
      ir_data <= '0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      fault   <= 1'b0;
      pending <= 1'b0;
      discard <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pending <= pending_next;
      discard <= discard_next;
      halted  <= halted_next;
      fault   <= fault_next;
      im_rd   <= im_rd_d;
      ir_wr   <= ir_wr_d;
      busy    <= busy_d;
      // pc_next already carries a same-cycle jump target
      if (im_rd_d) im_addr <= pc_next;
      if ((state == S_WAIT) && (state_next == S_DELIVER)) ir_data <= im_data;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending;
    discard_next = discard;
    halted_next  = halted;
    fault_next   = fault;
    case (state)
      S_IDLE: begin
        if (jump) pc_next = jump_addr;
        if ((fetch_req || pending) && !halted && !fault) state_next = S_REQ;
        pending_next = 1'b0;
        discard_next = 1'b0;
      end
      S_REQ: begin
        state_next = S_WAIT;
        if (fetch_req) pending_next = 1'b1;
        if (jump) begin
          pc_next      = jump_addr;
          discard_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (fetch_req) pending_next = 1'b1;
        if (jump) pc_next = jump_addr;
        if (im_valid) begin
          // A same-cycle jump kills the arriving word just like a stale one
          if (jump || discard) begin
            state_next   = S_REQ;
            discard_next = 1'b0;
          end else begin
            state_next = S_DELIVER;
          end
        end else begin
          if (jump) discard_next = 1'b1;
          if (expired) begin
            fault_next = 1'b1;
            state_next = S_HALT;
          end
        end
      end
      S_DELIVER: begin
        if (fetch_req) pending_next = 1'b1;
        pc_next = jump ? jump_addr : pc + AW'(1);
        if (ir_data == HALT_WORD) begin
          halted_next = 1'b1;
          state_next  = S_HALT;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_HALT: begin
        // Requests queued before the halt must not restart fetching later
        pending_next = 1'b0;
        discard_next = 1'b0;
        if (jump) begin
          pc_next     = jump_addr;
          halted_next = 1'b0;
          fault_next  = 1'b0;
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    im_rd_d = (state_next == S_REQ);
    ir_wr_d = (state_next == S_DELIVER);
    busy_d  = (state_next != S_IDLE);
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  fetch_req = 1'b0;
  logic  jump = 1'b0;
  addr_t jump_addr = '0;
  addr_t im_addr;
  logic  im_rd;
  word_t im_data = '0;
  logic  im_valid = 1'b0;
  word_t ir_data;
  logic  ir_wr;
  addr_t pc;
  logic  busy, halted, fault;

  int checks = 0;
  int errors = 0;

  // memory model: mem_lat = 0 means the memory never answers
  word_t mem [256];
  int    mem_lat = 2;
  int    resp_cnt = 0;
  addr_t lat_addr = '0;
  int    rd_count = 0;
  int    wr_count = 0;
  addr_t last_rd_addr = '0;
  word_t last_wr_data = '0;

  instr_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_req),
    .jump      (jump),
    .jump_addr (jump_addr),
    .im_addr   (im_addr),
    .im_rd     (im_rd),
    .im_data   (im_data),
    .im_valid  (im_valid),
    .ir_data   (ir_data),
    .ir_wr     (ir_wr),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      im_valid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt = resp_cnt - 1;
        if (resp_cnt == 0) begin
          im_valid = 1'b1;
          im_data  = mem[lat_addr];
        end
      end
      if (im_rd) begin
        rd_count     = rd_count + 1;
        last_rd_addr = im_addr;
        if (mem_lat != 0) begin
          resp_cnt = mem_lat;
          lat_addr = im_addr;
        end
      end
      if (ir_wr) begin
        wr_count     = wr_count + 1;
        last_wr_data = ir_data;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; fetch_req = 1'b0; jump = 1'b0; resp_cnt = 0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // on return the DUT is in the cycle after the request was sampled
  task automatic pulse_fetch();
    fetch_req = 1'b1;
    tick(1);
    fetch_req = 1'b0;
  endtask

  task automatic pulse_jump(input addr_t a);
    jump = 1'b1; jump_addr = a;
    tick(1);
    jump = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
    checks++; if (im_addr !== 8'h00) begin errors++; $display("FAIL reset_im_addr: got %h expected 00", im_addr); end
    checks++; if ({im_rd, ir_wr, busy, halted, fault} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {im_rd, ir_wr, busy, halted, fault}); end
    checks++; if (ir_data !== 16'h0000) begin errors++; $display("FAIL reset_ir_data: got %h expected 0000", ir_data); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    apply_reset();
    mem_lat = 2; mem[0] = 16'h1234;
    pulse_fetch();                              // cycle 1
    checks++; if (im_rd !== 1'b1) begin errors++; $display("FAIL basic_im_rd: got %b expected 1", im_rd); end
    checks++; if (im_addr !== 8'h00) begin errors++; $display("FAIL basic_im_addr: got %h expected 00", im_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    tick(2);                                    // cycle 3
    checks++; if ({im_rd, ir_wr} !== 2'b00) begin errors++; $display("FAIL basic_quiet_c3: got %b expected 00", {im_rd, ir_wr}); end
    tick(1);                                    // cycle 4
    checks++; if (ir_wr !== 1'b1) begin errors++; $display("FAIL basic_ir_wr: got %b expected 1", ir_wr); end
    checks++; if (ir_data !== 16'h1234) begin errors++; $display("FAIL basic_ir_data: got %h expected 1234", ir_data); end
    tick(1);                                    // cycle 5
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL basic_pc: got %h expected 01", pc); end
    checks++; if ({ir_wr, busy} !== 2'b00) begin errors++; $display("FAIL basic_idle: got %b expected 00", {ir_wr, busy}); end
  endtask

  task automatic test_back_to_back();
    int rd0, wr0;
    apply_reset();
    mem_lat = 5; mem[0] = 16'h1111; mem[1] = 16'hABCD;
    rd0 = rd_count; wr0 = wr_count;
    pulse_fetch();                              // cycle 1 (REQ)
    tick(1); fetch_req = 1'b1;                  // cycle 2 WAIT
    tick(1); fetch_req = 1'b0;
    tick(1); fetch_req = 1'b1;                  // cycle 4 WAIT
    tick(1); fetch_req = 1'b0;
    tick(1); fetch_req = 1'b1;                  // cycle 6 WAIT (valid arrives)
    tick(1); fetch_req = 1'b0;                  // cycle 7 DELIVER
    tick(2);                                    // cycle 9: pending refetch
    checks++; if (im_rd !== 1'b1) begin errors++; $display("FAIL b2b_refetch_rd: got %b expected 1", im_rd); end
    checks++; if (im_addr !== 8'h01) begin errors++; $display("FAIL b2b_refetch_addr: got %h expected 01", im_addr); end
    tick(15);
    checks++; if (rd_count - rd0 !== 2) begin errors++; $display("FAIL b2b_reads: got %0d expected 2", rd_count - rd0); end
    checks++; if (wr_count - wr0 !== 2) begin errors++; $display("FAIL b2b_writes: got %0d expected 2", wr_count - wr0); end
    checks++; if (last_wr_data !== 16'hABCD) begin errors++; $display("FAIL b2b_last_word: got %h expected abcd", last_wr_data); end
    checks++; if (pc !== 8'h02) begin errors++; $display("FAIL b2b_pc: got %h expected 02", pc); end
  endtask

  task automatic test_jump_discard();
    int wr0;
    apply_reset();
    mem_lat = 2; mem[0] = 16'hDEAD; mem[8'h40] = 16'h4040;
    wr0 = wr_count;
    pulse_fetch();                              // cycle 1
    tick(2);                                    // cycle 3: im_valid high
    checks++; if (im_valid !== 1'b1) begin errors++; $display("FAIL jump_setup_valid: got %b expected 1", im_valid); end
    pulse_jump(8'h40);                          // cycle 4: refetch
    checks++; if (im_rd !== 1'b1) begin errors++; $display("FAIL jump_refetch_rd: got %b expected 1", im_rd); end
    checks++; if (im_addr !== 8'h40) begin errors++; $display("FAIL jump_refetch_addr: got %h expected 40", im_addr); end
    checks++; if (ir_wr !== 1'b0) begin errors++; $display("FAIL jump_no_write: got %b expected 0", ir_wr); end
    tick(3);                                    // cycle 7: DELIVER
    checks++; if (ir_wr !== 1'b1 || ir_data !== 16'h4040) begin errors++; $display("FAIL jump_deliver: got wr=%b data=%h expected wr=1 data=4040", ir_wr, ir_data); end
    tick(1);
    checks++; if (pc !== 8'h41) begin errors++; $display("FAIL jump_pc: got %h expected 41", pc); end
    checks++; if (wr_count - wr0 !== 1) begin errors++; $display("FAIL jump_write_count: got %0d expected 1", wr_count - wr0); end
  endtask

  task automatic test_wrap();
    apply_reset();
    mem_lat = 2; mem[8'hFF] = 16'h0001;
    pulse_jump(8'hFF);
    checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL wrap_jump_pc: got %h expected ff", pc); end
    pulse_fetch();
    checks++; if (im_addr !== 8'hFF) begin errors++; $display("FAIL wrap_im_addr: got %h expected ff", im_addr); end
    tick(3);
    checks++; if (ir_wr !== 1'b1 || ir_data !== 16'h0001) begin errors++; $display("FAIL wrap_deliver: got wr=%b data=%h expected wr=1 data=0001", ir_wr, ir_data); end
    tick(1);
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h expected 00", pc); end
  endtask

  task automatic test_halt();
    int rd0;
    apply_reset();
    mem_lat = 2; mem[3] = 16'hFF00; mem[8'h10] = 16'h5A5A;
    pulse_jump(8'h03);
    pulse_fetch();
    tick(3);                                    // cycle 4
    checks++; if (ir_wr !== 1'b1 || ir_data !== 16'hFF00) begin errors++; $display("FAIL halt_word_written: got wr=%b data=%h expected wr=1 data=ff00", ir_wr, ir_data); end
    tick(1);
    checks++; if (halted !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL halt_flag: got halted=%b busy=%b expected 1 1", halted, busy); end
    rd0 = rd_count;
    pulse_fetch();
    tick(8);
    checks++; if (rd_count !== rd0) begin errors++; $display("FAIL halt_ignores_fetch: got %0d reads expected %0d", rd_count, rd0); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", halted); end
    pulse_jump(8'h10);
    checks++; if (halted !== 1'b0 || pc !== 8'h10 || busy !== 1'b0) begin errors++; $display("FAIL halt_jump_exit: got halted=%b pc=%h busy=%b expected 0 10 0", halted, pc, busy); end
    pulse_fetch();
    checks++; if (im_rd !== 1'b1 || im_addr !== 8'h10) begin errors++; $display("FAIL halt_refetch: got rd=%b addr=%h expected 1 10", im_rd, im_addr); end
    tick(3);
    checks++; if (ir_data !== 16'h5A5A) begin errors++; $display("FAIL halt_refetch_data: got %h expected 5a5a", ir_data); end
  endtask

  task automatic test_fault();
    int wr0;
    apply_reset();
    mem_lat = 0;
    wr0 = wr_count;
    pulse_fetch();                              // cycle 1; WAIT is cycles 2..16
    tick(15);                                   // cycle 16
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_early: got %b expected 0", fault); end
    tick(1);                                    // cycle 17
    checks++; if (fault !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL fault_set: got fault=%b busy=%b expected 1 1", fault, busy); end
    checks++; if (wr_count !== wr0) begin errors++; $display("FAIL fault_no_write: got %0d expected %0d", wr_count, wr0); end
    // reset in the middle of a WAIT
    apply_reset();
    pulse_jump(8'h22);
    pulse_fetch();
    tick(4);
    checks++; if (busy !== 1'b1 || im_addr !== 8'h22) begin errors++; $display("FAIL rstwait_setup: got busy=%b addr=%h expected 1 22", busy, im_addr); end
    rst = 1'b1;
    tick(1);
    checks++; if (pc !== 8'h00 || im_addr !== 8'h00) begin errors++; $display("FAIL rstwait_addr: got pc=%h im_addr=%h expected 00 00", pc, im_addr); end
    checks++; if ({im_rd, ir_wr, busy, halted, fault} !== 5'b0 || ir_data !== 16'h0) begin errors++; $display("FAIL rstwait_outputs: got flags=%b data=%h expected 00000 0000", {im_rd, ir_wr, busy, halted, fault}, ir_data); end
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = word_t'(16'hC000 + i);
    tick(1);
    test_reset();
    test_basic();
    test_back_to_back();
    test_jump_discard();
    test_wrap();
    test_halt();
    test_fault();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
